// File: rtl/shift_decode_pkg.sv
// Shared RV32I shift-decode constants and the decoded-command type.
package shift_decode_pkg;

    localparam logic [6:0] OP      = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic left;
        logic arr;
        logic imm_sel;
        logic illegal;
    } dec_t;

    function automatic logic [31:0] shamt_ext(input logic [4:0] shamt);
        return {27'b0, shamt};
    endfunction

endpackage

// File: rtl/shift_decode_comb.sv
// Pure combinational decode of an RV32I word into shift controls.
// Full encoding check only when SHIFT_DECODE_ILLEGAL_EN is defined.
module shift_decode_comb
    import shift_decode_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

`ifdef SHIFT_DECODE_ILLEGAL_EN
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal_op;
    logic       legal_fn;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign funct7      = instr[31:25];
    assign unused_bits = ^{instr[24:15], instr[11:7]};

    always_comb begin
        dec      = '0;
        legal_op = (opcode == OP) || (opcode == OP_IMM);
        legal_fn = ((funct3 == F3_SLL) && (funct7 == F7_BASE)) ||
                   ((funct3 == F3_SRL) && ((funct7 == F7_BASE) || (funct7 == F7_ALT)));
        if (legal_op && legal_fn) begin
            dec.left    = (funct3 == F3_SLL);
            dec.arr     = instr[30] && !dec.left;
            dec.imm_sel = (opcode == OP_IMM);
        end else begin
            dec.illegal = 1'b1;
        end
    end
`else
    logic unused_bits;

    // Minimal decode: bit 5 picks reg/imm, bit 14 picks right, bit 30 picks arithmetic.
    assign unused_bits = ^{instr[31], instr[29:15], instr[13:6], instr[4:0]};

    always_comb begin
        dec         = '0;
        dec.left    = !instr[14];
        dec.arr     = instr[30] && instr[14];
        dec.imm_sel = !instr[5];
    end
`endif

endmodule

// File: rtl/shift_decode.sv
// Shift decode stage: one-entry registered command buffer with handshake and a
// saturating handshake counter. SHIFT_DECODE_ILLEGAL_EN enables illegal-word detection.
module shift_decode
    import shift_decode_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic             out_left,
    output logic             out_arr,
    output logic [4:0]       out_rd,
    output logic             out_illegal,
    output logic [CNT_W-1:0] out_count
);

    dec_t             dec;
    logic             accept;
    logic             handshake;

    logic             valid_d,   valid_q;
    logic [31:0]      a_d,       a_q;
    logic [31:0]      b_d,       b_q;
    logic             left_d,    left_q;
    logic             arr_d,     arr_q;
    logic [4:0]       rd_d,      rd_q;
    logic             illegal_d, illegal_q;
    logic [CNT_W-1:0] count_d,   count_q;

    shift_decode_comb u_comb (
        .instr (instr),
        .dec   (dec)
    );

    assign in_ready  = !valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign handshake = valid_q && out_ready;

    always_comb begin
        valid_d   = valid_q;
        a_d       = a_q;
        b_d       = b_q;
        left_d    = left_q;
        arr_d     = arr_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;
        count_d   = count_q;

        if (handshake && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end

        // Flush wins over a same-cycle accept; the new word is dropped.
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            rd_d      = instr[11:7];
            illegal_d = dec.illegal;
            if (dec.illegal) begin
                a_d    = '0;
                b_d    = '0;
                left_d = 1'b0;
                arr_d  = 1'b0;
            end else begin
                a_d    = rs1_data;
                b_d    = dec.imm_sel ? shamt_ext(instr[24:20]) : rs2_data;
                left_d = dec.left;
                arr_d  = dec.arr;
            end
        end else if (handshake) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            left_q    <= 1'b0;
            arr_q     <= 1'b0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            left_q    <= left_d;
            arr_q     <= arr_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_a       = a_q;
    assign out_b       = b_q;
    assign out_left    = left_q;
    assign out_arr     = arr_q;
    assign out_rd      = rd_q;
    assign out_illegal = illegal_q;
    assign out_count   = count_q;

endmodule
